mode_ctrl_fsm: RTL and testbench

Parametrised mode-selection controller for the piano top level, the successor of the 2-bit mode FSM. A one-hot key press on the keyboard bus nominates a mode. A debounced confirm button commits it. A debounced back button returns to the menu. It adds debouncing, an arbitrary mode count, invalid-selection flagging and a separate pending/committed mode. Downstream play, auto-play and learn units consume `mode`, `active` and `signal`.

---
 rtl/mode_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_mode_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mode_ctrl_fsm.sv
// Mode-selection controller: one-hot key nominates a mode, debounced confirm commits it,
// debounced back returns to the menu. Includes the per-button debouncer used by the top.

module mode_ctrl_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             db;
  logic             db_q;
  logic             armed;

  // armed stays low until a debounced release is seen, so a button held through reset cannot commit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      db_q <= db;
      if (!db && !raw) begin
        armed <= 1'b1;
      end
      if (raw == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evt = db & ~db_q & armed;

endmodule

module mode_ctrl_fsm #(
  parameter int KEY_W        = 8,
  parameter int MODE_W       = 2,
  parameter int NUM_MODES    = 3,
  parameter int DB_CYCLES    = 4,
  parameter int DEFAULT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_board_in,
  input  logic              confirm,
  input  logic              back,
  output logic [MODE_W-1:0] mode,
  output logic [MODE_W-1:0] pending,
  output logic              active,
  output logic              signal,
  output logic              err
);

  typedef enum logic {
    MENU   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [MODE_W-1:0] mode_n, pending_n;
  logic              active_n, signal_n, err_n;
  logic              confirm_evt, back_evt;
  logic              key_onehot, key_valid;
  logic [MODE_W-1:0] key_sel;

  mode_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_confirm (
    .clk (clk),
    .rst (rst),
    .raw (confirm),
    .evt (confirm_evt)
  );

  mode_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_back (
    .clk (clk),
    .rst (rst),
    .raw (back),
    .evt (back_evt)
  );

  // Exactly one-hot keys only; all-zero and multi-hot never match any pattern
  always_comb begin
    key_onehot = 1'b0;
    key_valid  = 1'b0;
    key_sel    = '0;
    for (int k = 0; k < KEY_W; k++) begin
      if (key_board_in == (KEY_W'(1) << k)) begin
        key_onehot = 1'b1;
        if (k < NUM_MODES) begin
          key_valid = 1'b1;
          key_sel   = MODE_W'(k);
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode;
    pending_n = pending;
    active_n  = active;
    signal_n  = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      MENU: begin
        if (key_valid) begin
          pending_n = key_sel;
        end else if (key_onehot) begin
          err_n = 1'b1;
        end
        // A key arriving in the same cycle as confirm takes priority over the old nomination
        if (confirm_evt) begin
          mode_n   = key_valid ? key_sel : pending;
          active_n = 1'b1;
          signal_n = 1'b1;
          state_n  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (back_evt) begin
          active_n  = 1'b0;
          pending_n = mode;
          state_n   = MENU;
        end
      end
      default: state_n = MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MENU;
      mode    <= MODE_W'(DEFAULT_MODE);
      pending <= MODE_W'(DEFAULT_MODE);
      active  <= 1'b0;
      signal  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      mode    <= mode_n;
      pending <= pending_n;
      active  <= active_n;
      signal  <= signal_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_mode_ctrl_fsm.sv
// Scoreboard bench for mode_ctrl_fsm: a reference model pushes expected outputs per edge,
// popped and compared on the following falling edge, plus directed checks from the test plan.

module tb_mode_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] key_board_in;
  logic       confirm;
  logic       back;
  logic [1:0] mode;
  logic [1:0] pending;
  logic       active;
  logic       signal;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int sig_cnt  = 0;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] pending;
    logic       active;
    logic       signal;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [1:0] m_mode, m_pend;
  logic       m_act, m_sig, m_err, m_menu;
  int         m_cnt[2];
  logic       m_db[2], m_dbq[2], m_arm[2];

  mode_ctrl_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .key_board_in (key_board_in),
    .confirm      (confirm),
    .back         (back),
    .mode         (mode),
    .pending      (pending),
    .active       (active),
    .signal       (signal),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic [7:0] k, input logic c, input logic b);
    logic       raw[2];
    logic       evt[2];
    logic       onehot, valid;
    logic [1:0] sel;
    int         idx;
    raw[0] = c;
    raw[1] = b;
    if (r) begin
      m_mode = 2'd0; m_pend = 2'd0; m_act = 1'b0; m_sig = 1'b0; m_err = 1'b0; m_menu = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_db[i] = 1'b0; m_dbq[i] = 1'b0; m_arm[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) evt[i] = m_db[i] && !m_dbq[i] && m_arm[i];
      m_sig = 1'b0;
      m_err = 1'b0;
      if (m_menu) begin
        onehot = ($countones(k) == 1);
        idx    = $clog2(k);
        valid  = onehot && (idx < 3);
        sel    = valid ? 2'(idx) : m_pend;
        if (valid) m_pend = 2'(idx);
        else if (onehot) m_err = 1'b1;
        if (evt[0]) begin
          m_mode = sel; m_act = 1'b1; m_sig = 1'b1; m_menu = 1'b0;
        end
      end else if (evt[1]) begin
        m_act = 1'b0; m_pend = m_mode; m_menu = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!m_db[i] && !raw[i]) m_arm[i] = 1'b1;
        m_dbq[i] = m_db[i];
        if (raw[i] == m_db[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == 3) begin
          m_db[i] = !m_db[i]; m_cnt[i] = 0;
        end else m_cnt[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] k, input logic c, input logic b);
    exp_t e;
    rst = r; key_board_in = k; confirm = c; back = b;
    @(posedge clk);
    modelStep(r, k, c, b);
    e.mode = m_mode; e.pending = m_pend; e.active = m_act; e.signal = m_sig; e.err = m_err;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    checkOutput("sb_mode", 32'(mode), 32'(e.mode));
    checkOutput("sb_pending", 32'(pending), 32'(e.pending));
    checkOutput("sb_active", 32'(active), 32'(e.active));
    checkOutput("sb_signal", 32'(signal), 32'(e.signal));
    checkOutput("sb_err", 32'(err), 32'(e.err));
    if (signal === 1'b1) sig_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic press(input logic c, input logic b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, c, b);
  endtask

  initial begin
    logic       cur_c, cur_b;
    int         hold_c, hold_b;
    logic [7:0] k;

    // Reset with random keys and confirm held through it
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'($urandom));
    checkOutput("rst_mode", 32'(mode), 0);
    checkOutput("rst_pending", 32'(pending), 0);
    checkOutput("rst_active", 32'(active), 0);
    checkOutput("rst_signal", 32'(signal), 0);
    checkOutput("rst_err", 32'(err), 0);
    sig_cnt = 0;
    press(1'b1, 1'b0, 8);
    checkOutput("held_confirm_no_commit", 32'(active), 0);
    checkOutput("held_confirm_no_signal", 32'(sig_cnt), 0);
    idle(6);
    press(1'b1, 1'b0, 6);
    checkOutput("repress_commit", 32'(active), 1);
    checkOutput("repress_signal", 32'(sig_cnt), 1);

    // Reset in the middle of ACTIVE
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_active", 32'(active), 0);
    checkOutput("midrst_mode", 32'(mode), 0);
    idle(2);

    // Selection and commit latency
    applyStimulus(1'b0, 8'b0000_0100, 1'b0, 1'b0);
    checkOutput("sel_pending", 32'(pending), 2);
    sig_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 3) checkOutput("commit_not_early", 32'(active), 0);
      if (i == 4) checkOutput("commit_edge4_signal", 32'(signal), 1);
    end
    checkOutput("commit_signal_once", 32'(sig_cnt), 1);
    checkOutput("commit_mode", 32'(mode), 2);
    idle(6);

    // Back glitch in ACTIVE, then real back
    press(1'b0, 1'b1, 3);
    idle(3);
    checkOutput("back_glitch_active", 32'(active), 1);
    press(1'b0, 1'b1, 5);
    checkOutput("back_active", 32'(active), 0);
    checkOutput("back_mode", 32'(mode), 2);
    checkOutput("back_pending", 32'(pending), 2);
    idle(6);

    // Confirm glitch in MENU
    sig_cnt = 0;
    press(1'b1, 1'b0, 3);
    idle(3);
    checkOutput("confirm_glitch_active", 32'(active), 0);
    checkOutput("confirm_glitch_signal", 32'(sig_cnt), 0);

    // Invalid and ignored keys in MENU
    applyStimulus(1'b0, 8'b0001_0000, 1'b0, 1'b0);
    checkOutput("invalid_key_err", 32'(err), 1);
    idle(1);
    checkOutput("invalid_key_err_drop", 32'(err), 0);
    checkOutput("invalid_key_pending", 32'(pending), 2);
    applyStimulus(1'b0, 8'b0000_0011, 1'b0, 1'b0);
    checkOutput("multihot_err", 32'(err), 0);
    checkOutput("multihot_pending", 32'(pending), 2);

    // Recommit with unchanged pending
    sig_cnt = 0;
    press(1'b1, 1'b0, 6);
    checkOutput("recommit_signal", 32'(sig_cnt), 1);
    checkOutput("recommit_mode", 32'(mode), 2);
    idle(6);
    applyStimulus(1'b0, 8'b0001_0000, 1'b0, 1'b0);
    checkOutput("active_key_err", 32'(err), 0);
    applyStimulus(1'b0, 8'b0000_0001, 1'b0, 1'b0);
    checkOutput("active_key_pending", 32'(pending), 2);

    // Simultaneous buttons
    press(1'b1, 1'b1, 6);
    checkOutput("both_in_active", 32'(active), 0);
    idle(6);
    press(1'b1, 1'b1, 6);
    checkOutput("both_in_menu", 32'(active), 1);
    idle(6);
    press(1'b0, 1'b1, 6);
    idle(6);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, (i == 4) ? 8'b0000_0010 : 8'h00, 1'b1, 1'b0);
    checkOutput("key_with_confirm_mode", 32'(mode), 1);
    checkOutput("key_with_confirm_pending", 32'(pending), 1);
    idle(6);

    // Random traffic against the model
    cur_c = 1'b0; cur_b = 1'b0; hold_c = 0; hold_b = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold_c == 0) begin cur_c = 1'($urandom); hold_c = $urandom_range(1, 8); end
      if (hold_b == 0) begin cur_b = 1'($urandom); hold_b = $urandom_range(1, 8); end
      hold_c--; hold_b--;
      if ($urandom_range(0, 3) == 0) k = 8'(1 << $urandom_range(0, 7));
      else if ($urandom_range(0, 5) == 0) k = 8'($urandom);
      else k = 8'h00;
      applyStimulus(($urandom_range(0, 199) == 0), k, cur_c, cur_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
